// File: rtl/cpu_pkg.sv
// Shared defaults and FSM state encodings for the register file slice.
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_DROP} wr_state_t;
  typedef enum logic       {R_IDLE, R_HOLD}         rd_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, a lock sets it and a commit clears it.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock_valid,
  input  logic [ADDR_W-1:0] lock_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              pend_a,
  output logic              pend_b
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                lock_ok;

  assign lock_ok = lock_valid && !((ZERO_REG != 0) && (lock_addr == '0));

  // Set is applied after clear: a lock belongs to a newer instruction than the retiring write.
  always_comb begin
    pend_d = pend_q;
    if (clr_valid) pend_d[clr_addr] = 1'b0;
    if (lock_ok)   pend_d[lock_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend_a = pend_q[addr_a];
  assign pend_b = pend_q[addr_b];
endmodule

// File: rtl/register_file.sv
// Architectural register file: handshaked writeback port, 4-phase two-operand read port,
// hazard stall via the pending scoreboard and same-cycle write forwarding.
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              reg_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              lock_valid,
  input  logic [ADDR_W-1:0] lock_addr
);
  localparam int NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

  wr_state_t         wr_q, wr_d;
  rd_state_t         rd_q, rd_d;
  logic              reg_ack_q, reg_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic              commit, wr_keep;
  logic              pend1, pend2, hazard;
  logic              fwd1, fwd2;
  logic [DATA_W-1:0] op1, op2;

  // Write FSM: one commit per write_en assertion; W_DROP waits for write_en to be seen low.
  always_comb begin
    wr_d      = wr_q;
    reg_ack_d = 1'b0;
    commit    = 1'b0;
    case (wr_q)
      W_IDLE: if (write_en) begin
        commit    = 1'b1;
        reg_ack_d = 1'b1;
        wr_d      = W_ACK;
      end
      W_ACK:  wr_d = W_DROP;
      W_DROP: if (!write_en) wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
  end

  assign wr_keep = commit && !((ZERO_REG != 0) && (write_addr == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       regs_q <= '0;
    else if (wr_keep) regs_q[write_addr] <= write_data;
  end

  reg_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .lock_valid(lock_valid),
    .lock_addr (lock_addr),
    .clr_valid (commit),
    .clr_addr  (write_addr),
    .addr_a    (rs1_addr),
    .addr_b    (rs2_addr),
    .pend_a    (pend1),
    .pend_b    (pend2)
  );

  // A commit in this cycle both resolves the hazard and supplies the operand.
  assign fwd1   = commit && (write_addr == rs1_addr);
  assign fwd2   = commit && (write_addr == rs2_addr);
  assign hazard = (pend1 && !fwd1) || (pend2 && !fwd2);

  always_comb begin
    if ((ZERO_REG != 0) && (rs1_addr == '0)) op1 = '0;
    else if (fwd1)                           op1 = write_data;
    else                                     op1 = regs_q[rs1_addr];
    if ((ZERO_REG != 0) && (rs2_addr == '0)) op2 = '0;
    else if (fwd2)                           op2 = write_data;
    else                                     op2 = regs_q[rs2_addr];
  end

  always_comb begin
    rd_d     = rd_q;
    rd_ack_d = rd_ack_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    case (rd_q)
      R_IDLE: if (rd_req && !hazard) begin
        rs1_d    = op1;
        rs2_d    = op2;
        rd_ack_d = 1'b1;
        rd_d     = R_HOLD;
      end
      R_HOLD: if (!rd_req) begin
        rd_ack_d = 1'b0;
        rd_d     = R_IDLE;
      end
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q      <= W_IDLE;
      rd_q      <= R_IDLE;
      reg_ack_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      reg_ack_q <= reg_ack_d;
      rd_ack_q  <= rd_ack_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
    end
  end

  assign reg_ack  = reg_ack_q;
  assign rd_ack   = rd_ack_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
endmodule
